// File: rtl/dht_poll_scheduler_pkg.sv
// Shared types and constants for the DHT poll scheduler: FSM states, packet
// header byte, status-byte bit positions and the key rotation helper.
package dht_poll_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_READ,
        ST_CHECK,
        ST_SEND
    } state_e;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam int unsigned STATUS_CSUM_BIT    = 0;
    localparam int unsigned STATUS_TIMEOUT_BIT = 1;
    localparam int unsigned STATUS_RETRY_LSB   = 4;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [1:0] n);
        logic [7:0] r;
        unique case (n)
            2'd1:    r = {v[6:0], v[7]};
            2'd2:    r = {v[5:0], v[7:6]};
            2'd3:    r = {v[4:0], v[7:5]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dht_poll_scheduler_checksum.sv
// Combinational DHT frame check: the four data bytes summed modulo 256 must
// equal the trailing checksum byte.
module dht_checksum (
    input  logic [39:0] data,
    output logic        ok
);

    logic [7:0] sum;

    always_comb begin
        sum = data[39:32] + data[31:24] + data[23:16] + data[15:8];
        ok  = (sum == data[7:0]);
    end

endmodule

// File: rtl/dht_poll_scheduler.sv
// Periodically polls a DHT11 reader, validates the frame with retries and a
// sticky fault flag, and streams a 4-byte packet over a valid/ready UART port.
// Optional build macro SENSOR_SCRAMBLE_EN XORs payload bytes with a rotated KEY.
module dht_poll_scheduler
    import dht_poll_scheduler_pkg::*;
#(
    parameter int unsigned POLL_PERIOD  = 200000000,
    parameter int unsigned READ_TIMEOUT = 1000000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [7:0]  KEY          = 8'h5C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_poll,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic [39:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault,
    output logic [15:0] poll_count
);

    localparam int unsigned PCW = $clog2(POLL_PERIOD + 1);
    localparam int unsigned TCW = $clog2(READ_TIMEOUT + 1);
    localparam logic [PCW-1:0] PERIOD_LOAD  = PCW'(POLL_PERIOD - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(READ_TIMEOUT - 1);
    localparam logic [3:0]     RETRY_LIMIT  = 4'(MAX_RETRY);

`ifdef SENSOR_SCRAMBLE_EN
    localparam logic [7:0] MASK_1 = rotl8(KEY, 2'd1);
    localparam logic [7:0] MASK_2 = rotl8(KEY, 2'd2);
    localparam logic [7:0] MASK_3 = rotl8(KEY, 2'd3);
`else
    localparam logic [7:0] MASK_1 = 8'h00;
    localparam logic [7:0] MASK_2 = 8'h00;
    localparam logic [7:0] MASK_3 = 8'h00;
`endif

    state_e           state_q, state_d;
    logic [PCW-1:0]   period_cnt_q, period_cnt_d;
    logic [TCW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic [39:0]      rd_word_q, rd_word_d;
    logic             timeout_q, timeout_d;
    logic             csum_err_q, csum_err_d;
    logic [7:0]       last_hum_q, last_hum_d;
    logic [7:0]       last_temp_q, last_temp_d;
    logic             fault_q, fault_d;
    logic [15:0]      poll_count_q, poll_count_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             csum_ok;
    logic [7:0]       status_byte;

    dht_checksum u_checksum (
        .data (rd_word_q),
        .ok   (csum_ok)
    );

    assign fault      = fault_q;
    assign poll_count = poll_count_q;

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        to_cnt_d     = to_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        rd_word_d    = rd_word_q;
        timeout_d    = timeout_q;
        csum_err_d   = csum_err_q;
        last_hum_d   = last_hum_q;
        last_temp_d  = last_temp_q;
        fault_d      = fault_q;
        poll_count_d = poll_count_q;
        byte_idx_d   = byte_idx_q;
        rd_start     = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;

        status_byte                             = 8'h00;
        status_byte[STATUS_RETRY_LSB +: 4]      = retry_cnt_q;
        status_byte[STATUS_TIMEOUT_BIT]         = timeout_q;
        status_byte[STATUS_CSUM_BIT]            = csum_err_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    period_cnt_d = PERIOD_LOAD;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (force_poll || period_cnt_q == '0) begin
                    state_d = ST_START;
                end else begin
                    period_cnt_d = period_cnt_q - 1'b1;
                end
            end
            ST_START: begin
                rd_start  = 1'b1;
                to_cnt_d  = '0;
                timeout_d = 1'b0;
                state_d   = ST_READ;
            end
            ST_READ: begin
                // A completion in the final timeout cycle still counts as a read.
                if (rd_done) begin
                    rd_word_d = rd_data;
                    timeout_d = 1'b0;
                    state_d   = ST_CHECK;
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CHECK;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                csum_err_d = !timeout_q && !csum_ok;
                byte_idx_d = 2'd0;
                if (!timeout_q && csum_ok) begin
                    retry_cnt_d = 4'd0;
                    last_hum_d  = rd_word_q[39:32];
                    last_temp_d = rd_word_q[23:16];
                    fault_d     = 1'b0;
                    state_d     = ST_SEND;
                end else if (retry_cnt_q < RETRY_LIMIT) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    state_d     = ST_START;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                unique case (byte_idx_q)
                    2'd0: tx_data = HEADER_BYTE;
                    2'd1: tx_data = last_hum_q ^ MASK_1;
                    2'd2: tx_data = last_temp_q ^ MASK_2;
                    2'd3: tx_data = status_byte ^ MASK_3;
                endcase
                if (tx_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        poll_count_d = poll_count_q + 1'b1;
                        retry_cnt_d  = 4'd0;
                        byte_idx_d   = 2'd0;
                        period_cnt_d = PERIOD_LOAD;
                        state_d      = enable ? ST_WAIT : ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            to_cnt_q     <= '0;
            retry_cnt_q  <= 4'd0;
            rd_word_q    <= 40'd0;
            timeout_q    <= 1'b0;
            csum_err_q   <= 1'b0;
            last_hum_q   <= 8'h00;
            last_temp_q  <= 8'h00;
            fault_q      <= 1'b0;
            poll_count_q <= 16'h0000;
            byte_idx_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            to_cnt_q     <= to_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            rd_word_q    <= rd_word_d;
            timeout_q    <= timeout_d;
            csum_err_q   <= csum_err_d;
            last_hum_q   <= last_hum_d;
            last_temp_q  <= last_temp_d;
            fault_q      <= fault_d;
            poll_count_q <= poll_count_d;
            byte_idx_q   <= byte_idx_d;
        end
    end

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Scoreboard bench for dht_poll_scheduler: two instances (MAX_RETRY 3 and 0)
// share stimulus; a monitor pops expected UART bytes as they are accepted.
module tb_dht_poll_scheduler;

    localparam logic [7:0] TB_KEY = 8'h5C;
`ifdef SENSOR_SCRAMBLE_EN
    localparam bit SCR_EN = 1'b1;
`else
    localparam bit SCR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b, force_poll, rd_done, tx_ready;
    logic [39:0] rd_data;
    logic        rd_start_a, rd_start_b, tx_valid_a, tx_valid_b, fault_a, fault_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic [15:0] poll_count_a, poll_count_b;

    logic        sel;
    logic        rd_start_s, tx_valid_s, fault_s;
    logic [7:0]  tx_data_s;
    logic [15:0] poll_count_s;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_start = 0;
    int          lat_mode = 0;
    bit          withhold = 1'b0;
    logic [39:0] rd_word = 40'd0;
    logic [7:0]  sb_q[$];

    always #5 clk = ~clk;

    dht_poll_scheduler #(.POLL_PERIOD(100), .READ_TIMEOUT(50), .MAX_RETRY(3), .KEY(TB_KEY)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .force_poll(force_poll),
        .rd_start(rd_start_a), .rd_done(rd_done), .rd_data(rd_data),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .fault(fault_a), .poll_count(poll_count_a)
    );

    dht_poll_scheduler #(.POLL_PERIOD(100), .READ_TIMEOUT(50), .MAX_RETRY(0), .KEY(TB_KEY)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .force_poll(force_poll),
        .rd_start(rd_start_b), .rd_done(rd_done), .rd_data(rd_data),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .fault(fault_b), .poll_count(poll_count_b)
    );

    assign rd_start_s   = sel ? rd_start_b   : rd_start_a;
    assign tx_valid_s   = sel ? tx_valid_b   : tx_valid_a;
    assign tx_data_s    = sel ? tx_data_b    : tx_data_a;
    assign fault_s      = sel ? fault_b      : fault_a;
    assign poll_count_s = sel ? poll_count_b : poll_count_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] v);
        logic [15:0] kk;
        kk = {8'h00, TB_KEY} << idx;
        return SCR_EN ? (v ^ (kk[7:0] | kk[15:8])) : v;
    endfunction

    task automatic push_packet(input logic [7:0] hum, input logic [7:0] temp, input logic [7:0] status);
        sb_q.push_back(8'hA5);
        sb_q.push_back(exp_byte(1, hum));
        sb_q.push_back(exp_byte(2, temp));
        sb_q.push_back(exp_byte(3, status));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_force();
        force_poll = 1'b1;
        cycle();
        force_poll = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            cycle();
            n++;
        end
        check(tag, sb_q.size(), 0);
        repeat (2) cycle();
    endtask

    // Accepted bytes are compared against the scoreboard; latency to the
    // first tx_valid is measured from rd_done or from rd_start.
    int since_done  = 0;
    int since_start = 0;
    logic tx_valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rd_done) since_done = 0; else if (since_done < 100000) since_done++;
        if (rd_start_s) since_start = 0; else if (since_start < 100000) since_start++;
        if (!rst && tx_valid_s && !tx_valid_prev) begin
            if (lat_mode == 1) check("rd_done_to_tx_valid", since_done, 2);
            if (lat_mode == 2) check("rd_start_to_tx_valid", since_start, 52);
        end
        tx_valid_prev = tx_valid_s;
        if (!rst && tx_valid_s && tx_ready) begin
            if (sb_q.size() == 0) check("unexpected_byte", {24'h0, tx_data_s}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'h0, tx_data_s}, {24'h0, sb_q.pop_front()});
        end
    end

    // Behavioural DHT reader: answers each rd_start after a few cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_start_s) begin
                n_start++;
                if (!withhold) begin
                    repeat (3) @(posedge clk);
                    #1 rd_done = 1'b1;
                    rd_data = rd_word;
                    @(posedge clk);
                    #1 rd_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; force_poll = 1'b0;
        rd_done = 1'b0; rd_data = 40'd0; tx_ready = 1'b1; sel = 1'b0;
        repeat (3) cycle();
        check("rst_rd_start", rd_start_a, 0);
        check("rst_tx_valid", tx_valid_a, 0);
        check("rst_tx_data", tx_data_a, 0);
        check("rst_fault", fault_a, 0);
        check("rst_poll_count", poll_count_a, 0);
        rst = 1'b0;
        cycle();

        // Automatic poll after the full period, good frame.
        rd_word = {8'd40, 8'd0, 8'd25, 8'd0, 8'd65};
        lat_mode = 1; n_start = 0;
        push_packet(8'd40, 8'd25, 8'h00);
        en_a = 1'b1;
        cycle();
        n = 0;
        while (!rd_start_s && n < 1000) begin
            cycle();
            n++;
        end
        check("poll_period_edges", n, 100);
        wait_drain("drain_good");
        check("good_poll_count", poll_count_s, 1);
        check("good_fault", fault_s, 0);
        check("good_starts", n_start, 1);

        // Bad checksum on every read: three retries then fault with last-good data.
        rd_word = {8'd40, 8'd0, 8'd25, 8'd0, 8'd0};
        lat_mode = 0; n_start = 0;
        push_packet(8'd40, 8'd25, 8'h31);
        pulse_force();
        check("force_in_wait", rd_start_s, 1);
        wait_drain("drain_bad_csum");
        check("bad_starts", n_start, 4);
        check("bad_fault", fault_s, 1);
        check("bad_poll_count", poll_count_s, 2);

        // Good frame with a force_poll during READ and a 10-cycle tx stall.
        rd_word = {8'd55, 8'd3, 8'd22, 8'd7, 8'd87};
        lat_mode = 1; n_start = 0;
        push_packet(8'd55, 8'd22, 8'h00);
        pulse_force();
        cycle();
        pulse_force();
        n = 0;
        while (sb_q.size() != 2 && n < 1000) begin
            cycle();
            n++;
        end
        check("reach_stall_point", sb_q.size(), 2);
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("stall_tx_valid", tx_valid_s, 1);
            check("stall_tx_data", tx_data_s, sb_q[0]);
        end
        tx_ready = 1'b1;
        wait_drain("drain_stall");
        check("stall_starts", n_start, 1);
        check("stall_fault_cleared", fault_s, 0);
        check("stall_poll_count", poll_count_s, 3);

        // Timeout with no retries, then a good read clears the fault.
        en_a = 1'b0;
        repeat (2) cycle();
        sel = 1'b1; withhold = 1'b1; lat_mode = 2; n_start = 0;
        push_packet(8'd0, 8'd0, 8'h02);
        en_b = 1'b1;
        repeat (3) cycle();
        pulse_force();
        check("b_force_in_wait", rd_start_s, 1);
        wait_drain("drain_timeout");
        check("timeout_fault", fault_s, 1);
        check("timeout_starts", n_start, 1);
        withhold = 1'b0; lat_mode = 1;
        rd_word = {8'd40, 8'd0, 8'd25, 8'd0, 8'd65};
        push_packet(8'd40, 8'd25, 8'h00);
        pulse_force();
        wait_drain("drain_recover");
        check("recover_fault", fault_s, 0);
        check("recover_poll_count", poll_count_s, 2);

        // Reset while a packet is being offered.
        en_b = 1'b0; sel = 1'b0; lat_mode = 0; n_start = 0;
        tx_ready = 1'b0; en_a = 1'b1;
        repeat (2) cycle();
        pulse_force();
        n = 0;
        while (!tx_valid_s && n < 200) begin
            cycle();
            n++;
        end
        check("send_offered", tx_valid_s, 1);
        check("send_header", tx_data_s, 8'hA5);
        rst = 1'b1;
        cycle();
        check("rst_send_tx_valid", tx_valid_s, 0);
        check("rst_send_tx_data", tx_data_s, 0);
        check("rst_send_poll_count", poll_count_s, 0);
        rst = 1'b0; en_a = 1'b0; tx_ready = 1'b1;
        cycle();
        check("idle_tx_valid", tx_valid_s, 0);
        repeat (150) cycle();
        check("idle_no_poll", n_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht_poll_scheduler.md
DHT_POLL_SCHEDULER -- requirements
Module: dht_poll_scheduler

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 200000000, meaning clk cycles between automatic polls (DHT11 needs at least 1 s).
REQ-002 SHALL have parameter READ_TIMEOUT, default 1000000, meaning maximum clk cycles in READ before the read counts as a timeout failure.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning retries after a failed read before reporting a fault (range 0..15).
REQ-004 SHALL have parameter KEY, default 8'h5C, meaning the scramble key byte (see Configuration).
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: enable in 1, level, allows polling; force_poll in 1, one-cycle pulse requesting an immediate poll.
REQ-007 SHALL have ports: rd_start out 1, one-cycle start pulse to the DHT reader; rd_done in 1, one-cycle pulse with rd_data valid; rd_data in 40, {hum_int,hum_dec,temp_int,temp_dec,checksum} with MSB byte first.
REQ-008 SHALL have ports: tx_data out 8, UART byte; tx_valid out 1, byte offered; tx_ready in 1, UART transmitter accepts the byte.
REQ-009 SHALL have ports: fault out 1, sticky sensor-fault flag; poll_count out 16, count of completed packets.

Function
REQ-010 SHALL implement the states IDLE, WAIT, START, READ, CHECK and SEND.
REQ-011 IDLE: when enable=1, SHALL load the period counter with POLL_PERIOD-1 and go to WAIT.
REQ-012 WAIT: SHALL decrement the counter each cycle and go to START at 0 or on force_poll; when enable=0, SHALL go to IDLE (enable takes priority over force_poll).
REQ-013 START: SHALL assert rd_start for exactly one cycle, clear the timeout counter and go to READ.
REQ-014 READ: on rd_done, SHALL capture rd_data and go to CHECK; when the timeout counter reaches READ_TIMEOUT-1 without rd_done, SHALL go to CHECK flagged as timeout; rd_done in the same cycle as the timeout SHALL win.
REQ-015 CHECK: pass means (b4+b3+b2+b1) mod 256 == b0 and no timeout; on pass SHALL clear retry_cnt, store hum_int/temp_int as last-good values, clear fault and go to SEND.
REQ-016 CHECK on fail: if retry_cnt<MAX_RETRY, SHALL increment retry_cnt and go to START; otherwise SHALL set fault=1 and go to SEND using the last-good values.
REQ-017 SEND: SHALL emit 4 bytes in order: 8'hA5, hum_int, temp_int, status; status = {retry_cnt[3:0], 2'b00, timeout, csum_err}.
REQ-018 SHALL hold tx_valid and tx_data stable until tx_valid&&tx_ready, then advance one byte; after the 4th acceptance SHALL increment poll_count (wrapping 16'hFFFF->0), clear retry_cnt, reload the period counter and go to WAIT (IDLE if enable=0).
REQ-019 Latency: tx_valid SHALL rise 2 cycles after the rd_done cycle on a pass.
REQ-020 force_poll outside WAIT/IDLE SHALL be ignored; rd_done outside READ SHALL be ignored; enable=0 during START/READ/CHECK/SEND SHALL let the current packet complete.

Reset
REQ-021 On rst, SHALL go to IDLE with: rd_start=0, tx_valid=0, tx_data=0, fault=0, poll_count=0, retry_cnt=0, last-good values=0; rst mid-SEND SHALL drop tx_valid at that edge.

Configuration
REQ-022 With SENSOR_SCRAMBLE_EN defined, bytes 1..3 SHALL be XORed with KEY rotated left by the byte index (1..3) and the header SHALL be left unscrambled; without the macro, bytes SHALL be sent in plain form and KEY SHALL be unused.

Structure
REQ-023 A shared package SHALL hold the state enum, the header constant 8'hA5 and the status bit positions.
REQ-024 A sub-module dht_checksum (combinational 40-bit checksum check) SHALL be used; all other logic SHALL stay in one module.

Verification
REQ-025 POLL_PERIOD=100, rd_data={8'd40,0,8'd25,0,8'd65}, tx_ready=1 -> rd_start at cycle 100 after enable; bytes A5,28,19,00; poll_count=1.
REQ-026 Bad checksum (b0=8'd0) on every read, MAX_RETRY=3 -> 4 rd_start pulses; bytes A5,<last-good>,<last-good>,31; fault=1.
REQ-027 rd_done withheld, READ_TIMEOUT=50, MAX_RETRY=0 -> status 8'h02 after 50 READ cycles; a later good read clears fault.
REQ-028 tx_ready low for 10 cycles mid-packet -> tx_data held unchanged; no byte lost or duplicated.
REQ-029 force_poll in WAIT -> rd_start next cycle; force_poll during READ -> no extra rd_start; rst asserted during SEND -> tx_valid=0 and IDLE next cycle.
REQ-030 SENSOR_SCRAMBLE_EN defined, KEY=8'h5C, data as in REQ-025 -> bytes A5, 28^B8, 19^71, 00^E2.
